// File: rtl/puf_ro_ctrl_pkg.sv
// puf_ro_pkg: shared FSM state encoding and default widths for the RO PUF controller.
`timescale 1ns/1ps
package puf_ro_pkg;

    localparam int N_RO_DEF       = 16;
    localparam int CNT_W_DEF      = 16;
    localparam int WIN_W_DEF      = 16;
    localparam int SETTLE_CYC_DEF = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        COUNT   = 3'd2,
        COMPARE = 3'd3,
        NEXT    = 3'd4,
        DONE    = 3'd5
    } puf_ro_ctrl_state_e;

endpackage

// File: rtl/puf_ro_ctrl_edge_cnt.sv
// puf_ro_edge_cnt: 2-flop synchronizer, rising-edge detect and saturating edge counter
// for one asynchronous RO output.
`timescale 1ns/1ps
module puf_ro_edge_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ro,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    // sync[1:0] is the metastability pair, sync[2] the previous sample for edge detect
    logic [2:0] sync;
    logic       rise;

    // sample the RO into the clock domain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync <= '0;
        else          sync <= {sync[1:0], i_ro};
    end

    assign rise = sync[1] & ~sync[2];

    // count synchronized rising edges; hold at all-ones instead of wrapping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                  o_cnt <= '0;
        else if (i_clr)                o_cnt <= '0;
        else if (i_en && rise && !(&o_cnt)) o_cnt <= o_cnt + 1'b1;
    end

endmodule

// File: rtl/puf_ro_ctrl.sv
// puf_ro_ctrl: steps through the RO pairs one at a time (settle, count, compare) and
// publishes one response bit per pair. Optional macro PUF_RO_CTRL_TIE_MASK_EN adds
// o_tie, flagging pairs whose counts were equal or hit saturation.
`timescale 1ns/1ps
module puf_ro_ctrl
    import puf_ro_pkg::*;
#(
    parameter int N_RO       = N_RO_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WIN_W      = WIN_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [WIN_W-1:0]    i_win_len,
    input  logic [N_RO-1:0]     i_ro,
    output logic [N_RO-1:0]     o_ro_en,
    output logic                o_busy,
    output logic                o_valid,
    output logic [N_RO/2-1:0]   o_resp
`ifdef PUF_RO_CTRL_TIE_MASK_EN
   ,output logic [N_RO/2-1:0]   o_tie
`endif
);

    localparam int N_RESP = N_RO / 2;
    localparam int KW     = (N_RESP > 1) ? $clog2(N_RESP) : 1;
    localparam int SW     = $clog2(SETTLE_CYC + 1);
    localparam int TW     = (WIN_W > SW) ? WIN_W : SW;

    puf_ro_ctrl_state_e state;
    logic [KW-1:0]      k;
    logic [TW-1:0]      tmr;
    logic [WIN_W-1:0]   win_m1;
    logic [N_RESP-1:0]  shadow;
    logic [CNT_W-1:0]   cnt_a, cnt_b;
    logic               ro_a, ro_b;
    logic               cnt_clr, cnt_en;
`ifdef PUF_RO_CTRL_TIE_MASK_EN
    logic [N_RESP-1:0]  shadow_tie;
`endif

    // route the active pair onto the shared counters; the mux switches only in NEXT,
    // so any glitch it causes lands in SETTLE while the counters are held clear
    always_comb begin
        ro_a = 1'b0;
        ro_b = 1'b0;
        for (int j = 0; j < N_RESP; j++) begin
            if (k == KW'(j)) begin
                ro_a = i_ro[2*j];
                ro_b = i_ro[2*j+1];
            end
        end
    end

    // enable only the active pair, and only while it is settling or being counted
    always_comb begin
        o_ro_en = '0;
        if (state == SETTLE || state == COUNT) begin
            for (int j = 0; j < N_RESP; j++) begin
                if (k == KW'(j)) o_ro_en[2*j +: 2] = 2'b11;
            end
        end
    end

    assign o_busy  = (state != IDLE);
    assign cnt_clr = (state == SETTLE);
    assign cnt_en  = (state == COUNT);

    puf_ro_edge_cnt #(.CNT_W(CNT_W)) u_cnt_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ro    (ro_a),
        .i_clr   (cnt_clr),
        .i_en    (cnt_en),
        .o_cnt   (cnt_a)
    );

    puf_ro_edge_cnt #(.CNT_W(CNT_W)) u_cnt_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ro    (ro_b),
        .i_clr   (cnt_clr),
        .i_en    (cnt_en),
        .o_cnt   (cnt_b)
    );

    // sequencer: abort beats everything, otherwise walk settle/count/compare per pair
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            k       <= '0;
            tmr     <= '0;
            win_m1  <= '0;
            shadow  <= '0;
            o_resp  <= '0;
            o_valid <= 1'b0;
`ifdef PUF_RO_CTRL_TIE_MASK_EN
            shadow_tie <= '0;
            o_tie      <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            if (i_abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            // a zero window behaves like a one-cycle window
                            win_m1 <= (i_win_len == '0) ? '0 : i_win_len - 1'b1;
                            k      <= '0;
                            tmr    <= TW'(SETTLE_CYC - 1);
                            state  <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (tmr == '0) begin
                            tmr   <= TW'(win_m1);
                            state <= COUNT;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    COUNT: begin
                        if (tmr == '0) state <= COMPARE;
                        else           tmr   <= tmr - 1'b1;
                    end
                    COMPARE: begin
                        for (int j = 0; j < N_RESP; j++) begin
                            if (k == KW'(j)) begin
                                shadow[j] <= (cnt_a > cnt_b);
`ifdef PUF_RO_CTRL_TIE_MASK_EN
                                shadow_tie[j] <= (cnt_a == cnt_b) || (&cnt_a) || (&cnt_b);
`endif
                            end
                        end
                        state <= NEXT;
                    end
                    NEXT: begin
                        if (k == KW'(N_RESP - 1)) begin
                            state <= DONE;
                        end else begin
                            k     <= k + 1'b1;
                            tmr   <= TW'(SETTLE_CYC - 1);
                            state <= SETTLE;
                        end
                    end
                    DONE: begin
                        o_resp  <= shadow;
                        o_valid <= 1'b1;
`ifdef PUF_RO_CTRL_TIE_MASK_EN
                        o_tie   <= shadow_tie;
`endif
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
